// File: rtl/debouncer_mc.sv
// debouncer_mc: multi-channel debouncer for asynchronous, noisy inputs.
// Each channel has a SYNC-deep synchronizer and a stability counter.
// The debounced level changes only after the synchronized input has held a
// new level for cfg_eff consecutive enabled clocks, where cfg_eff is cfg_cnt
// with 0 treated as 1. Registered rise/fall pulses fire on the edge that
// updates dout. evt is a sticky flag per channel: set by any transition,
// cleared by evt_clr, and a set wins over a clear in the same cycle.
module debouncer_mc #(
    parameter int NCH  = 8,
    parameter int CW   = 16,
    parameter int SYNC = 2      // synchronizer depth, 2 or more
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic [NCH-1:0] din,
    input  logic           en,
    input  logic [CW-1:0]  cfg_cnt,
    input  logic [NCH-1:0] evt_clr,
    output logic [NCH-1:0] dout,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic [NCH-1:0] evt
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [NCH-1:0] sync_q [SYNC];
    logic [CW-1:0]  cnt_q  [NCH];
    logic [CW-1:0]  cnt_d  [NCH];
    logic [NCH-1:0] dout_q, dout_d;
    logic [NCH-1:0] rise_q, rise_d;
    logic [NCH-1:0] fall_q, fall_d;
    logic [NCH-1:0] evt_q,  evt_d;
    logic [CW-1:0]  limit;
    logic [NCH-1:0] s;

    // cfg_eff - 1. Comparing against this with >= means a newly lowered
    // cfg_cnt takes effect at once, even when cnt is already past it.
    assign limit = (cfg_cnt == '0) ? '0 : (cfg_cnt - CNT_ONE);
    assign s     = sync_q[SYNC-1];

    // Synchronizer chain: the last stage feeds the decision logic.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int k = 0; k < SYNC; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Per-channel next-state logic: count mismatch cycles, commit at cfg_eff.
    always_comb begin
        dout_d = dout_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!en || (s[i] == dout_q[i])) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= limit) begin
                dout_d[i] = s[i];
                rise_d[i] = s[i];
                fall_d[i] = ~s[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        evt_d = (evt_q & ~evt_clr) | rise_d | fall_d;
    end

    // State registers: counters, debounced level, pulses and sticky flags.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
            dout_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            evt_q  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            evt_q  <= evt_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign evt  = evt_q;

endmodule

// File: tb/tb_debouncer_mc.sv
// Testbench for debouncer_mc: directed scenarios plus random traffic.
// A reference model tracks, per edge, the synchronized level and enable
// history and declares a transition once the last cfg_eff enabled edges all
// disagreed with the current debounced level. Expected outputs go into a
// queue; a monitor pops and compares one entry after every clock edge.
module tb_debouncer_mc;

    localparam int NCH  = 8;
    localparam int CW   = 16;
    localparam int SYNC = 2;
    localparam int HMAX = 64;

    logic           aclk = 1'b0;
    logic           areset;
    logic [NCH-1:0] din;
    logic           en;
    logic [CW-1:0]  cfg_cnt;
    logic [NCH-1:0] evt_clr;
    logic [NCH-1:0] dout, rise, fall, evt;

    debouncer_mc #(.NCH(NCH), .CW(CW), .SYNC(SYNC)) dut (
        .aclk    (aclk),
        .areset  (areset),
        .din     (din),
        .en      (en),
        .cfg_cnt (cfg_cnt),
        .evt_clr (evt_clr),
        .dout    (dout),
        .rise    (rise),
        .fall    (fall),
        .evt     (evt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [NCH-1:0] dout;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
        logic [NCH-1:0] evt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [NCH-1:0] got,
                         input logic [NCH-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at t=%0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [NCH-1:0] m_pipe [SYNC];
    logic [NCH-1:0] m_dout = '0, m_rise = '0, m_fall = '0, m_evt = '0;
    logic [NCH-1:0] hist_s[$];
    bit             hist_en[$];
    logic [NCH-1:0] m_s, m_nd, m_nr, m_nf;
    int             m_eff, m_k;
    exp_t           m_e;

    // Model evaluation on every rising edge, using the inputs held there.
    always @(posedge aclk) begin
        if (areset) begin
            for (int j = 0; j < SYNC; j++) m_pipe[j] = '0;
            hist_s.delete();
            hist_en.delete();
            m_dout = '0; m_rise = '0; m_fall = '0; m_evt = '0;
        end else begin
            m_s   = m_pipe[SYNC-1];
            m_eff = (cfg_cnt == 0) ? 1 : int'(cfg_cnt);
            m_nd  = m_dout;
            m_nr  = '0;
            m_nf  = '0;
            for (int ch = 0; ch < NCH; ch++) begin
                if (en && (m_s[ch] != m_dout[ch])) begin
                    // length of the run of earlier enabled, disagreeing edges
                    m_k = 0;
                    while (m_k < m_eff - 1 && m_k < hist_s.size() &&
                           hist_en[m_k] && (hist_s[m_k][ch] != m_dout[ch]))
                        m_k++;
                    if (m_k >= m_eff - 1) begin
                        m_nd[ch] = m_s[ch];
                        m_nr[ch] = m_s[ch];
                        m_nf[ch] = ~m_s[ch];
                    end
                end
            end
            m_evt = (m_evt & ~evt_clr) | m_nr | m_nf;
            hist_s.push_front(m_s);
            hist_en.push_front(en);
            if (hist_s.size() > HMAX) begin
                void'(hist_s.pop_back());
                void'(hist_en.pop_back());
            end
            for (int j = SYNC - 1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
            m_pipe[0] = din;
            m_dout = m_nd; m_rise = m_nr; m_fall = m_nf;
        end
        m_e.dout = m_dout; m_e.rise = m_rise; m_e.fall = m_fall; m_e.evt = m_evt;
        exp_q.push_back(m_e);
    end

    // ---------------- monitor ----------------
    exp_t mon_e;
    // Compare DUT outputs with the oldest expected entry after each edge.
    always @(posedge aclk) begin
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty got=0 entries expected>=1 at t=%0t", $time);
        end else begin
            mon_e = exp_q.pop_front();
            check("sb_dout", dout, mon_e.dout);
            check("sb_rise", rise, mon_e.rise);
            check("sb_fall", fall, mon_e.fall);
            check("sb_evt",  evt,  mon_e.evt);
            check("rise_fall_exclusive", rise & fall, '0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog got=timeout expected=finish at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        areset  = 1'b1;
        din     = 8'hFF;
        en      = 1'b1;
        cfg_cnt = 16'd10;
        evt_clr = '0;
        cyc(5);
        check("reset_dout", dout, '0);
        check("reset_evt",  evt,  '0);

        // Test 1: latency with cfg_cnt=10 -> transition at edge 12
        areset = 1'b0;
        din    = 8'h01;
        wait_edges(11);
        check("t1_dout_edge11", dout, 8'h00);
        wait_edges(1);
        check("t1_dout_edge12", dout, 8'h01);
        check("t1_rise_edge12", rise, 8'h01);
        wait_edges(1);
        check("t1_rise_edge13", rise, 8'h00);
        check("t1_evt_edge13",  evt,  8'h01);
        @(negedge aclk);

        // Test 2: glitch rejection on channel 1
        din[1] = 1'b1; cyc(8);
        din[1] = 1'b0; cyc(15);
        check("t2_no_rise", dout & 8'h02, 8'h00);
        din[1] = 1'b1; cyc(5);
        din[1] = 1'b0; cyc(1);
        din[1] = 1'b1;
        wait_edges(11);
        check("t2_rise_edge11", rise & 8'h02, 8'h00);
        wait_edges(1);
        check("t2_rise_edge12", rise & 8'h02, 8'h02);
        @(negedge aclk);

        // Test 3: cfg_cnt=0 behaves as 1 -> transition at edge 3
        cfg_cnt = 16'd0;
        din[3]  = 1'b1;
        wait_edges(2);
        check("t3_dout_edge2", dout & 8'h08, 8'h00);
        wait_edges(1);
        check("t3_dout_edge3", dout & 8'h08, 8'h08);
        @(negedge aclk);

        // Test 4: sticky evt on channel 2
        din[2] = 1'b1; cyc(10);
        evt_clr = '1; cyc(1); evt_clr = '0;
        din[2] = 1'b0; cyc(20);
        check("t4_evt_held", evt & 8'h04, 8'h04);
        evt_clr = 8'h04; cyc(1); evt_clr = '0; cyc(4);
        check("t4_evt_cleared", evt & 8'h04, 8'h00);
        din[2] = 1'b1; cyc(10);
        evt_clr = 8'h04; cyc(1); evt_clr = '0; cyc(3);
        din[2] = 1'b0;
        cyc(2);
        evt_clr = 8'h04;
        wait_edges(1);
        check("t4_fall_coincident", fall & 8'h04, 8'h04);
        check("t4_set_wins",        evt  & 8'h04, 8'h04);
        @(negedge aclk);
        evt_clr = '0;

        // Test 5: multi-channel simultaneous update, cfg_cnt=4 -> edge 6
        cfg_cnt = 16'd4;
        din = 8'h00; cyc(20);
        din = 8'hA5;
        wait_edges(5);
        check("t5_dout_edge5", dout, 8'h00);
        wait_edges(1);
        check("t5_dout_edge6", dout, 8'hA5);
        check("t5_rise_edge6", rise, 8'hA5);
        @(negedge aclk);
        din = 8'h00; cyc(20);
        din = 8'hA5; cyc(3);
        areset = 1'b1; cyc(1);
        areset = 1'b0;
        check("t5_reset_mid", dout, 8'h00);
        cyc(20);

        // Test 6: enable drop mid-count, cfg_cnt=10
        areset = 1'b1; cyc(1); areset = 1'b0;
        din = 8'h00; cfg_cnt = 16'd10; cyc(5);
        din = 8'h10; cyc(7);
        en = 1'b0; cyc(15);
        check("t6_hold_while_disabled", dout, 8'h00);
        en = 1'b1;
        wait_edges(9);
        check("t6_dout_edge9", dout & 8'h10, 8'h00);
        wait_edges(1);
        check("t6_dout_edge10", dout & 8'h10, 8'h10);
        @(negedge aclk);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int ch = 0; ch < NCH; ch++)
                if ($urandom_range(7) == 0) din[ch] = ~din[ch];
            if (en) en = ($urandom_range(40) != 0);
            else    en = ($urandom_range(9) == 0);
            for (int ch = 0; ch < NCH; ch++)
                evt_clr[ch] = ($urandom_range(15) == 0);
            if ((n % 64) == 0) cfg_cnt = CW'($urandom_range(6));
            areset = ($urandom_range(499) == 0);
            cyc(1);
        end
        areset = 1'b0; evt_clr = '0;
        cyc(3);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debouncer_mc.md
Name: debouncer_mc

Overview:
Multi-channel, run-time-configurable debouncer for asynchronous, mechanically noisy inputs such as buttons, external triggers and interlocks.
- Each channel has its own input synchronizer and stability counter.
- A channel's output changes only after its synchronized input has held a new level for a programmable number of consecutive clocks.
- Per-channel edge pulses and sticky event flags go to downstream control logic and register banks.

Parameters:
NCH, 8, number of independent channels.
CW, 16, width of stability counter and cfg_cnt.
SYNC, 2, number of synchronizer flops per channel; minimum 2.

Ports:
aclk  in  1  clock.
areset  in  1  reset (synchronous, active-high).
din  in  NCH  asynchronous raw inputs.
en  in  1  global debounce enable.
cfg_cnt  in  CW  number of consecutive stable cycles required; 0 is treated as 1.
evt_clr  in  NCH  per-channel clear for evt.
dout  out  NCH  debounced level.
rise  out  NCH  one-cycle pulse on a dout 0->1 transition.
fall  out  NCH  one-cycle pulse on a dout 1->0 transition.
evt  out  NCH  sticky flag, set on any dout transition.

Behaviour:
Clock and reset:
- Single clock domain, aclk.
- areset is synchronous and active-high. Every register is evaluated on the aclk rising edge.
- Reset: all synchronizer flops, cnt, dout, rise, fall and evt go to 0 on the first edge at which areset is sampled high.
- Reset asserted mid-count or mid-transition: all state is discarded. dout = 0 even if din is high.
- After reset release, a high din produces a normal rise after full latency.

Synchronizer:
- din[i] passes through a SYNC-deep flop chain.
- s[i] is the last stage of the chain.

Effective count:
- cfg_eff = (cfg_cnt == 0) ? 1 : cfg_cnt.

Per-channel counter (channel i, every edge, areset low):
- en == 0: cnt <= 0. dout held, rise/fall = 0. The synchronizer keeps running.
- s == dout: cnt <= 0. rise/fall = 0.
- s != dout and cnt >= cfg_eff-1:
  - dout <= s, cnt <= 0.
  - rise <= s, fall <= ~s, on the same edge as the dout update.
- s != dout otherwise: cnt <= cnt+1. rise/fall = 0.
- The >= comparison applies cfg_cnt changes immediately. Lowering cfg_cnt below the current cnt causes a transition on the next mismatch edge.
- The counter never wraps, because cnt < cfg_eff <= 2^CW-1.

Latency:
- Count the edge that first samples the new din level as edge 1.
- dout, rise and fall update on edge SYNC+cfg_eff.
- This assumes din, and therefore s, stays stable and en stays high.

Glitch rejection:
- Any single cycle with s == dout during a count resets cnt to 0.
- The full cfg_eff count then restarts.

rise and fall:
- Registered pulses, exactly one cycle wide.
- Never both high on the same channel in the same cycle.

evt:
- evt[i] <= (evt[i] & ~evt_clr[i]) | rise[i] | fall[i], where rise/fall are the next-state values.
- If a set and a clear coincide, set wins.
- Clearing with no new event: evt drops on the next edge.

Channel independence:
- Channels are fully independent.
- Simultaneous transitions on several channels update on the same edge.

Test Plan:
1. Reset with din=8'hFF held 5 cycles -> dout/rise/fall/evt = 0. Release with cfg_cnt=10, en=1, din[0]=1 from edge 1 -> dout[0]=1 and rise[0]=1 (one cycle) at edge 12, evt[0]=1 from edge 12.
2. Glitch: cfg_cnt=10, din[1]=1 for 8 cycles then 0 -> dout, rise, evt stay 0. Then din[1]=1 for 5 cycles, 0 for 1 cycle, 1 held -> rise[1] occurs exactly 12 edges after the final 0->1 sample.
3. cfg_cnt=0, din[3] 0->1 -> dout[3] rises at edge 3, identical to cfg_cnt=1.
4. Sticky flag: dout[2]=1, evt cleared; din[2]=0 -> fall[2] one cycle, evt[2]=1 held for 20 cycles. Pulse evt_clr[2] -> evt[2]=0 next edge. Repeat with evt_clr[2] coincident with a new fall -> evt[2] stays 1.
5. Multi-channel and reset mid-count: din 8'h00->8'hA5, cfg_cnt=4 -> dout=8'hA5 and rise=8'hA5 on the same edge (edge 6). Repeat, asserting areset at edge 4 -> dout stays 8'h00 and counts restart after release.
6. Enable: en=0 at count 5 of 10 -> no transition while en=0. en=1 again -> transition occurs 10 edges after re-enable.
